// File: rtl/bus_mux_pkg.sv
// Shared definitions for the registered datapath bus multiplexer:
// select-pattern classes and source-code helpers derived from the register count.
package bus_mux_pkg;

    typedef enum logic [1:0] {
        SEL_IDLE     = 2'd0,
        SEL_LEGAL    = 2'd1,
        SEL_CONFLICT = 2'd2,
        SEL_RMULTI   = 2'd3
    } sel_class_e;

    // Source ids: 0..n-1 are the general registers, then G, DIN, MEM, IDLE.
    function automatic int calc_src_w(input int n);
        return $clog2(n + 4);
    endfunction

    function automatic int src_g(input int n);
        return n;
    endfunction

    function automatic int src_din(input int n);
        return n + 1;
    endfunction

    function automatic int src_mem(input int n);
        return n + 2;
    endfunction

    function automatic int src_idle(input int n);
        return n + 3;
    endfunction

    function automatic int onehot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_mux_reg_onehot_encoder.sv
// One-hot decoder for the register select vector; the MSB maps to index 0
// so that bit N-1 names R0.
module onehot_encoder
    import bus_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = onehot_idx_w(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic             any_o,
    output logic             multi_o,
    output logic [IDX_W-1:0] idx_o
);

    assign any_o   = |vec_i;
    // Clearing the lowest set bit leaves something only when two or more were set.
    assign multi_o = |(vec_i & (vec_i - N'(1)));

    // Index of the set bit; only meaningful when exactly one bit is set.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(N - 1 - i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus multiplexer: priority DIN > G > MEM > Rout, one cycle
// of latency, with detection and saturating counting of illegal select patterns.
module bus_mux_reg
    import bus_mux_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int ERR_CNT_W = 8,
    parameter int SRC_W     = calc_src_w(NUM_REGS)
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [NUM_REGS-1:0]        Rout,
    input  logic                       DINout,
    input  logic                       Gout,
    input  logic                       Memout,
    input  logic                       Stall,
    input  logic                       err_clr,
    input  logic [NUM_REGS*DATA_W-1:0] Rdata,
    input  logic [DATA_W-1:0]          DINout_data,
    input  logic [DATA_W-1:0]          Gout_data,
    input  logic [DATA_W-1:0]          Memout_data,
    output logic [DATA_W-1:0]          BusWires,
    output logic                       bus_valid,
    output logic [SRC_W-1:0]           bus_src,
    output logic                       sel_err,
    output logic                       err_sticky,
    output logic [ERR_CNT_W-1:0]       err_count
);

    localparam int IDX_W = onehot_idx_w(NUM_REGS);
    localparam logic [SRC_W-1:0]     SRC_G    = SRC_W'(src_g(NUM_REGS));
    localparam logic [SRC_W-1:0]     SRC_DIN  = SRC_W'(src_din(NUM_REGS));
    localparam logic [SRC_W-1:0]     SRC_MEM  = SRC_W'(src_mem(NUM_REGS));
    localparam logic [SRC_W-1:0]     SRC_IDLE = SRC_W'(src_idle(NUM_REGS));
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

    logic                 r_any_s;
    logic                 r_multi_s;
    logic [IDX_W-1:0]     r_idx_s;
    logic [2:0]           grp_cnt_s;
    sel_class_e           sel_class_s;
    logic                 illegal_s;
    logic [DATA_W-1:0]    reg_data_s;

    logic [DATA_W-1:0]    bus_q,    bus_d;
    logic                 valid_q,  valid_d;
    logic [SRC_W-1:0]     src_q,    src_d;
    logic                 err_q,    err_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q,    cnt_d;

    onehot_encoder #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_rout_enc (
        .vec_i   (Rout),
        .any_o   (r_any_s),
        .multi_o (r_multi_s),
        .idx_o   (r_idx_s)
    );

    assign reg_data_s = Rdata[r_idx_s * DATA_W +: DATA_W];
    assign grp_cnt_s  = {2'b00, DINout} + {2'b00, Gout} + {2'b00, Memout} + {2'b00, r_any_s};

    // Classify the select pattern; a conflict takes precedence over a multi-hot Rout.
    always_comb begin
        sel_class_s = SEL_IDLE;
        if (grp_cnt_s > 3'd1) begin
            sel_class_s = SEL_CONFLICT;
        end else if (r_multi_s) begin
            sel_class_s = SEL_RMULTI;
        end else if (grp_cnt_s == 3'd1) begin
            sel_class_s = SEL_LEGAL;
        end else begin
            sel_class_s = SEL_IDLE;
        end
    end

    assign illegal_s = (sel_class_s == SEL_CONFLICT) || (sel_class_s == SEL_RMULTI);

    // Bus datapath next state: priority load, or hold with the IDLE tag.
    always_comb begin
        bus_d   = bus_q;
        valid_d = valid_q;
        src_d   = src_q;
        if (!Stall) begin
            case (sel_class_s)
                SEL_LEGAL, SEL_CONFLICT: begin
                    valid_d = 1'b1;
                    if (DINout) begin
                        bus_d = DINout_data;
                        src_d = SRC_DIN;
                    end else if (Gout) begin
                        bus_d = Gout_data;
                        src_d = SRC_G;
                    end else if (Memout) begin
                        bus_d = Memout_data;
                        src_d = SRC_MEM;
                    end else begin
                        bus_d = reg_data_s;
                        src_d = SRC_W'(r_idx_s);
                    end
                end
                SEL_RMULTI, SEL_IDLE: begin
                    valid_d = 1'b0;
                    src_d   = SRC_IDLE;
                end
                default: begin
                    valid_d = 1'b0;
                    src_d   = SRC_IDLE;
                end
            endcase
        end else begin
            bus_d   = bus_q;
            valid_d = valid_q;
            src_d   = src_q;
        end
    end

    // Error tracking ignores Stall; a same-cycle error beats err_clr.
    always_comb begin
        err_d    = illegal_s;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (illegal_s) begin
            sticky_d = 1'b1;
            if (err_clr) begin
                cnt_d = ERR_CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (err_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else begin
            sticky_d = sticky_q;
            cnt_d    = cnt_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            bus_q    <= '0;
            valid_q  <= 1'b0;
            src_q    <= SRC_IDLE;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign BusWires   = bus_q;
    assign bus_valid  = valid_q;
    assign bus_src    = src_q;
    assign sel_err    = err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed vector bench for bus_mux_reg; a second instance with a 2-bit error
// counter shares the stimulus to exercise counter saturation.
module tb_bus_mux_reg;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int SW = 4;

    logic              Clock = 1'b0;
    logic              Resetn, DINout, Gout, Memout, Stall, err_clr;
    logic [NR-1:0]     Rout;
    logic [NR*DW-1:0]  Rdata;
    logic [DW-1:0]     DINout_data, Gout_data, Memout_data;

    logic [DW-1:0]     bus_a, bus_b;
    logic              valid_a, valid_b, serr_a, serr_b, sticky_a, sticky_b;
    logic [SW-1:0]     src_a, src_b;
    logic [7:0]        cnt_a;
    logic [1:0]        cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    bus_mux_reg #(.DATA_W(DW), .NUM_REGS(NR), .ERR_CNT_W(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .Memout(Memout), .Stall(Stall), .err_clr(err_clr), .Rdata(Rdata),
        .DINout_data(DINout_data), .Gout_data(Gout_data), .Memout_data(Memout_data),
        .BusWires(bus_a), .bus_valid(valid_a), .bus_src(src_a), .sel_err(serr_a),
        .err_sticky(sticky_a), .err_count(cnt_a)
    );

    bus_mux_reg #(.DATA_W(DW), .NUM_REGS(NR), .ERR_CNT_W(2)) dut_sat (
        .Clock(Clock), .Resetn(Resetn), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .Memout(Memout), .Stall(Stall), .err_clr(err_clr), .Rdata(Rdata),
        .DINout_data(DINout_data), .Gout_data(Gout_data), .Memout_data(Memout_data),
        .BusWires(bus_b), .bus_valid(valid_b), .bus_src(src_b), .sel_err(serr_b),
        .err_sticky(sticky_b), .err_count(cnt_b)
    );

    typedef struct {
        logic          rst;
        logic [NR-1:0] rout;
        logic          din, g, mem, stall, clr;
        logic [DW-1:0] din_d, g_d, mem_d;
        logic [DW-1:0] e_bus;
        logic          e_valid;
        logic [SW-1:0] e_src;
        logic          e_err, e_sticky;
        logic [7:0]    e_cnt;
        logic [1:0]    e_cnt2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [NR-1:0] rout, input logic din, input logic g,
                       input logic mem, input logic stall, input logic clr, input logic [DW-1:0] din_d,
                       input logic [DW-1:0] g_d, input logic [DW-1:0] mem_d, input logic [DW-1:0] e_bus,
                       input logic e_valid, input logic [SW-1:0] e_src, input logic e_err,
                       input logic e_sticky, input logic [7:0] e_cnt, input logic [1:0] e_cnt2);
        vec_t v;
        v.rst = rst; v.rout = rout; v.din = din; v.g = g; v.mem = mem; v.stall = stall; v.clr = clr;
        v.din_d = din_d; v.g_d = g_d; v.mem_d = mem_d;
        v.e_bus = e_bus; v.e_valid = e_valid; v.e_src = e_src; v.e_err = e_err;
        v.e_sticky = e_sticky; v.e_cnt = e_cnt; v.e_cnt2 = e_cnt2;
        vecs.push_back(v);
    endtask

    initial begin
        // Ri values: R0..R7
        Rdata = {16'h7E7E, 16'h6666, 16'h5A5A, 16'h4444, 16'h3333, 16'h1234, 16'h1111, 16'h00FF};
        Resetn = 1'b0; Rout = 8'h00; DINout = 1'b0; Gout = 1'b0; Memout = 1'b0;
        Stall = 1'b0; err_clr = 1'b0;
        DINout_data = 16'h0000; Gout_data = 16'h0000; Memout_data = 16'h0000;

        //   rst  rout        din  g    mem  stl  clr  din_d     g_d       mem_d     bus       vld  src    err  stk  cnt    cnt2
        add(1'b1, 8'h00,      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'h0000,1'b0,4'd11,1'b0,1'b0,8'd0,2'd0);
        add(1'b0, 8'b00100000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'h1234,1'b1,4'd2, 1'b0,1'b0,8'd0,2'd0);
        add(1'b0, 8'h00,      1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h5555,16'h0000,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd1,2'd1);
        add(1'b0, 8'h00,      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'hABCD,1'b0,4'd11,1'b0,1'b1,8'd1,2'd1);
        add(1'b0, 8'b10000000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'h00FF,1'b1,4'd0, 1'b0,1'b1,8'd1,2'd1);
        add(1'b0, 8'b10000001,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'h00FF,1'b0,4'd11,1'b1,1'b1,8'd2,2'd2);
        add(1'b0, 8'h00,      1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,16'h7777,16'h00FF,1'b0,4'd11,1'b0,1'b1,8'd2,2'd2);
        add(1'b0, 8'h00,      1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h7777,16'h7777,1'b1,4'd10,1'b0,1'b1,8'd2,2'd2);
        add(1'b0, 8'h00,      1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h5555,16'h0000,16'h5555,1'b1,4'd8, 1'b0,1'b1,8'd2,2'd2);
        add(1'b0, 8'b00000001,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h7777,16'h7777,1'b1,4'd10,1'b1,1'b1,8'd3,2'd3);
        add(1'b0, 8'h00,      1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,16'h0000,16'h7777,1'b0,4'd11,1'b0,1'b0,8'd0,2'd0);
        add(1'b0, 8'b00000001,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'h7E7E,1'b1,4'd7, 1'b0,1'b0,8'd0,2'd0);
        add(1'b0, 8'h00,      1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h5555,16'h0000,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd1,2'd1);
        add(1'b0, 8'h00,      1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h5555,16'h0000,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd2,2'd2);
        add(1'b0, 8'h00,      1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h5555,16'h0000,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd3,2'd3);
        add(1'b0, 8'h00,      1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h5555,16'h0000,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd4,2'd3);
        add(1'b0, 8'h00,      1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h5555,16'h0000,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd5,2'd3);
        add(1'b0, 8'h00,      1'b1,1'b0,1'b1,1'b0,1'b1,16'hABCD,16'h0000,16'h7777,16'hABCD,1'b1,4'd9, 1'b1,1'b1,8'd1,2'd1);
        add(1'b0, 8'h00,      1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,16'h0000,16'hABCD,1'b0,4'd11,1'b0,1'b0,8'd0,2'd0);
        add(1'b0, 8'b01000000,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0000,16'h5555,16'h0000,16'hABCD,1'b0,4'd11,1'b1,1'b1,8'd1,2'd1);
        add(1'b1, 8'h00,      1'b1,1'b1,1'b0,1'b1,1'b1,16'hABCD,16'h5555,16'h0000,16'h0000,1'b0,4'd11,1'b0,1'b0,8'd0,2'd0);
        add(1'b0, 8'h00,      1'b1,1'b0,1'b0,1'b0,1'b0,16'h0F0F,16'h0000,16'h0000,16'h0F0F,1'b1,4'd9, 1'b0,1'b0,8'd0,2'd0);

        foreach (vecs[i]) begin
            @(negedge Clock);
            Resetn = vecs[i].rst; Rout = vecs[i].rout; DINout = vecs[i].din; Gout = vecs[i].g;
            Memout = vecs[i].mem; Stall = vecs[i].stall; err_clr = vecs[i].clr;
            DINout_data = vecs[i].din_d; Gout_data = vecs[i].g_d; Memout_data = vecs[i].mem_d;
            @(posedge Clock);
            #1;
            check("bus",    i, 32'(bus_a),    32'(vecs[i].e_bus));
            check("valid",  i, 32'(valid_a),  32'(vecs[i].e_valid));
            check("src",    i, 32'(src_a),    32'(vecs[i].e_src));
            check("sel_err",i, 32'(serr_a),   32'(vecs[i].e_err));
            check("sticky", i, 32'(sticky_a), 32'(vecs[i].e_sticky));
            check("count",  i, 32'(cnt_a),    32'(vecs[i].e_cnt));
            check("count2", i, 32'(cnt_b),    32'(vecs[i].e_cnt2));
            check("bus2",   i, 32'(bus_b),    32'(vecs[i].e_bus));
        end

        // Inputs changing between edges must not reach the outputs before the next edge.
        @(negedge Clock);
        Resetn = 1'b0; Rout = 8'h00; DINout = 1'b0; Gout = 1'b1; Memout = 1'b0;
        Stall = 1'b0; err_clr = 1'b0; Gout_data = 16'hBEEF;
        #1;
        check("nocomb_bus", 100, 32'(bus_a), 32'h0000_0F0F);
        check("nocomb_src", 100, 32'(src_a), 32'd9);
        @(posedge Clock);
        #1;
        check("g_bus", 101, 32'(bus_a), 32'h0000_BEEF);
        check("g_src", 101, 32'(src_a), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
